// File: rtl/mant_sub_serial_if.sv
// Handshake bundle for mant_sub_serial: operand pair in (valid/ready), result out (valid/ready).
interface mant_sub_serial_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero
  );
endinterface

// File: rtl/mant_sub_serial.sv
// Slice-serial mantissa subtractor: diff = a - b, one SLICE-bit slice per clock.
// Define MANT_SUB_ABS_EN to return |a - b| (extra slice-serial negate pass); borrow is the sign.
module mant_sub_serial #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic            clk,
  input  logic            rst,
  mant_sub_serial_if.slave io
);
  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef MANT_SUB_ABS_EN
  localparam logic [1:0] NEG  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result;
  logic             borrow_r;
  logic             zero_r;

  logic [SLICE-1:0] op_x;
  logic [SLICE-1:0] op_y;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] res_next;

  // One slice of the adder: {carry_out, sum} = x + y + cin.
  function automatic logic [SLICE:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
  endfunction

  // Operand selection for the active slice; NEG reuses the same adder as ~r + carry.
  always_comb begin
    op_x = '0;
    op_y = '0;
    for (int i = 0; i < NS; i++) begin
      if (k == KW'(i)) begin
        op_x = a_r[i*SLICE +: SLICE];
        op_y = ~b_r[i*SLICE +: SLICE];
      end
    end
`ifdef MANT_SUB_ABS_EN
    if (state == NEG) begin
      op_y = '0;
      for (int i = 0; i < NS; i++) begin
        if (k == KW'(i)) begin
          op_x = ~result[i*SLICE +: SLICE];
        end
      end
    end
`endif
    sum = slice_add(op_x, op_y, carry);
  end

  always_comb begin
    res_next = result;
    for (int i = 0; i < NS; i++) begin
      if (k == KW'(i)) begin
        res_next[i*SLICE +: SLICE] = sum[SLICE-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      result   <= '0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_r    <= io.a;
            b_r    <= io.b;
            k      <= '0;
            carry  <= 1'b1;
            zero_r <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= sum[SLICE];
          k      <= k + 1'b1;
          if (k == K_LAST) begin
            k        <= '0;
            borrow_r <= ~sum[SLICE];
            zero_r   <= (res_next == '0);
`ifdef MANT_SUB_ABS_EN
            if (~sum[SLICE]) begin
              carry <= 1'b1;
              state <= NEG;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end
        end
`ifdef MANT_SUB_ABS_EN
        NEG: begin
          result <= res_next;
          carry  <= sum[SLICE];
          k      <= k + 1'b1;
          if (k == K_LAST) begin
            k      <= '0;
            zero_r <= (res_next == '0);
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          if (io.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.diff      = result;
  assign io.borrow    = borrow_r;
  assign io.zero      = zero_r;
endmodule
